// File: rtl/stage_mem.sv
// Memory-access stage of the br32 pipeline. One EX-produced instruction sits
// in a slot register. Loads and stores drive the data-memory bus, load data is
// merged into the result, and IF/ID/EX are frozen while an access is pending.
// A watchdog counter aborts requests that never see dmem_ready.
module stage_mem #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_res,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  input  logic        ex_w_rd,
  input  logic        ex_w_cr,
  input  logic [1:0]  ex_cmp_res,
  input  logic [1:0]  ex_mem_op,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_signed,
  input  logic        ex_bubble,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_res,
  output logic [4:0]  mem_rd,
  output logic        mem_w_rd,
  output logic        mem_w_cr,
  output logic [1:0]  mem_cmp_res,
  output logic        mem_bubble,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic        mem_bus_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  addr,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    case (addr)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'd0:    v = {{24{sgn & b[7]}}, b};
      2'd1:    v = {{16{sgn & h[15]}}, h};
      default: v = rdata;
    endcase
    return v;
  endfunction

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_strb(input logic [1:0] addr,
                                            input logic [1:0] size);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << addr;
      2'd1:    s = addr[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Store data replicated onto every lane so the strobes pick the right one.
  function automatic logic [31:0] store_data(input logic [31:0] wdata,
                                             input logic [1:0]  size);
    logic [31:0] d;
    case (size)
      2'd0:    d = {4{wdata[7:0]}};
      2'd1:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  logic [31:0]      r_pc, r_res, r_wdata;
  logic [4:0]       r_rd;
  logic             r_w_rd, r_w_cr, r_signed, r_bubble;
  logic [1:0]       r_cmp, r_op, r_size;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_mem_op, w_mis, w_access, w_store, w_timeout;

  // Classify the slot: memory op, misalignment, and the watchdog expiry.
  always_comb begin
    w_mem_op  = !r_bubble && ((r_op == 2'd1) || (r_op == 2'd2));
    w_mis     = 1'b0;
    if (w_mem_op) begin
      if (r_size == 2'd1) begin
        w_mis = r_res[0];
      end else if (r_size >= 2'd2) begin
        w_mis = (r_res[1:0] != 2'b00);
      end else begin
        w_mis = 1'b0;
      end
    end else begin
      w_mis = 1'b0;
    end
    w_access  = w_mem_op && !w_mis;
    w_store   = w_access && (r_op == 2'd2);
    w_timeout = (r_state == S_WAIT) && !dmem_ready && (r_cnt == CNT_MAX);
  end

  // Bus drive and writeback outputs; all derived from the slot and the bus.
  always_comb begin
    dmem_req     = w_access;
    dmem_we      = w_store;
    dmem_addr    = {r_res[31:2], 2'b00};
    dmem_wdata   = 32'h0000_0000;
    dmem_wstrb   = 4'b0000;
    if (w_store) begin
      dmem_wdata = store_data(r_wdata, r_size);
      dmem_wstrb = store_strb(r_res[1:0], r_size);
    end else begin
      dmem_wdata = 32'h0000_0000;
      dmem_wstrb = 4'b0000;
    end
    mem_stall    = w_access && !dmem_ready && !w_timeout;
    mem_misalign = w_mis;
    mem_bus_err  = w_timeout;
    mem_bubble   = r_bubble | mem_stall | w_mis | w_timeout;
    mem_w_rd     = r_w_rd & !mem_bubble;
    mem_w_cr     = r_w_cr & !mem_bubble;
    mem_pc       = r_pc;
    mem_rd       = r_rd;
    mem_cmp_res  = r_cmp;
    if (w_access && (r_op == 2'd1)) begin
      mem_res = load_extract(dmem_rdata, r_res[1:0], r_size, r_signed);
    end else begin
      mem_res = r_res;
    end
  end

  // Slot register: capture EX whenever the stage is not stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= 32'h0000_0000;
      r_res    <= 32'h0000_0000;
      r_wdata  <= 32'h0000_0000;
      r_rd     <= 5'd0;
      r_w_rd   <= 1'b0;
      r_w_cr   <= 1'b0;
      r_cmp    <= 2'd0;
      r_op     <= 2'd0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_bubble <= 1'b1;
    end else if (!mem_stall) begin
      r_pc     <= ex_pc;
      r_res    <= ex_res;
      r_wdata  <= ex_wdata;
      r_rd     <= ex_rd;
      r_w_rd   <= ex_w_rd;
      r_w_cr   <= ex_w_cr;
      r_cmp    <= ex_cmp_res;
      r_op     <= ex_mem_op;
      r_size   <= ex_mem_size;
      r_signed <= ex_mem_signed;
      r_bubble <= ex_bubble;
    end
  end

  // Access FSM: track a pending request and count its wait cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access && !dmem_ready) begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_ONE;
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (dmem_ready || w_timeout || !w_access) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
